// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the RV32I load-store unit.
//   - funct3 encodings for loads and stores (size class in bits [1:0],
//     unsigned flag in bit 2)
//   - FSM state encoding
//   - helpers classifying a request as misaligned or carrying an illegal funct3
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Byte accesses never fault; halfwords need addr[0]=0; words need addr[1:0]=00.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic res;
    case (funct3)
      F3_H, F3_HU: res = addr_lo[0];
      F3_W:        res = (addr_lo != 2'b00);
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic illegal_funct3(input logic we, input logic [2:0] funct3);
    logic res;
    if (we) begin
      res = (funct3 > F3_W);
    end else begin
      res = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: word-aligned data-memory bus with req/gnt/rvalid handshake.
//   master (LSU side): drives mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                      mem_be_o; receives mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   slave  (memory side): the mirror image.
// Signal names are written from the LSU's point of view.
interface lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_fmt.sv
// lsu_fmt: combinational data formatting for the LSU.
//   st_*: store lane steering -- replicates the byte/halfword across the word
//         and builds the byte enables from the low address bits.
//   ld_*: load extraction -- picks the byte/halfword lane and sign- or
//         zero-extends it to 32 bits.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_data_o = '0;
    st_be_o   = '0;
    case (st_funct3_i)
      F3_B: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_be_o   = 4'b0001 << st_addr_lo_i;
      end
      F3_H: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_be_o   = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        st_data_o = st_data_i;
        st_be_o   = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = ld_rdata_i[8*ld_addr_lo_i +: 8];
    ld_half   = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I memory-stage load-store unit, one transaction in flight.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   req_valid_i/req_ready_o : request handshake from execute (ready only in IDLE)
//   req_we_i, req_funct3_i, req_addr_i, req_wdata_i : operation descriptor
//   rsp_valid_o             : one-cycle completion pulse
//   err_o                   : misaligned / illegal funct3, valid with rsp_valid_o
//   ld_data_o               : extended load result, held until the next load
//   mem                     : data-memory bus (lsu_if.master)
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] ld_data_o,
  output logic        err_o,
  lsu_if.master       mem
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] ld_fmt;
  logic        req_bad;

  // Store steering works on the incoming request so the bus payload is
  // registered at accept; load extraction works on the latched lane info.
  lsu_fmt u_fmt (
    .st_funct3_i  (req_funct3_i),
    .st_addr_lo_i (req_addr_i[1:0]),
    .st_data_i    (req_wdata_i),
    .st_data_o    (st_data),
    .st_be_o      (st_be),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_lo_q),
    .ld_rdata_i   (mem.mem_rdata_i),
    .ld_data_o    (ld_fmt)
  );

  assign req_bad = illegal_funct3(req_we_i, req_funct3_i)
                || misaligned(req_funct3_i, req_addr_i[1:0]);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          funct3_d  = req_funct3_i;
          addr_lo_d = req_addr_i[1:0];
          addr_d    = {req_addr_i[31:2], 2'b00};
          wdata_d   = st_data;
          be_d      = st_be;
          err_d     = req_bad;
          // Faulting requests skip the bus entirely.
          state_d   = req_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // A same-cycle rvalid here is not ours and is deliberately ignored.
        if (mem.mem_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid_i) begin
          ld_data_d = ld_fmt;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign rsp_valid_o     = (state_q == S_DONE);
  assign err_o           = err_q;
  assign ld_data_o       = ld_data_q;
  assign mem.mem_req_o   = (state_q == S_REQ);
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_be_o    = be_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu. Stimulus pushes expected bus requests and
// responses; a bus responder and a response monitor pop and compare.
module tb_lsu;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    bit          err;
    logic [31:0] ld;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] ld_data_o;
  logic        err_o;

  lsu_if bus ();

  lsu dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid_o),
    .ld_data_o    (ld_data_o),
    .err_o        (err_o),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  bus_t        exp_bus[$];
  rsp_t        exp_rsp[$];
  logic [31:0] ref_mem[64];
  logic [31:0] bmem[64];
  logic [31:0] mdl_ld = '0;
  logic [31:0] exp_ld_now = '0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  bit          spur_rv = 0;
  int          tx_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [1:0] off);
    bit illegal;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return illegal || ((int'(off) % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * int'(off));
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return {24'h0, sh[7:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    ref_mem[addr[7:2]] = val;
    bmem[addr[7:2]]    = val;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},  {31'h0, req_ready_o}, 32'd1);
    chk({tag, "_memreq"}, {31'h0, bus.mem_req_o}, 32'd0);
    chk({tag, "_rsp"},    {31'h0, rsp_valid_o}, 32'd0);
    chk({tag, "_err"},    {31'h0, err_o}, 32'd0);
    chk({tag, "_ld"},     ld_data_o, 32'd0);
    chk({tag, "_be"},     {28'h0, bus.mem_be_o}, 32'd0);
    chk({tag, "_we"},     {31'h0, bus.mem_we_o}, 32'd0);
    chk({tag, "_addr"},   bus.mem_addr_o, 32'd0);
    chk({tag, "_wdata"},  bus.mem_wdata_o, 32'd0);
  endtask

  // Issue one operation, push its expectations, return the response latency
  // in cycles counted from the accept edge (-1 when no response arrived).
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    bit          err;
    bit          got;
    int          size;
    int          idx;
    logic [1:0]  off;
    bus_t        b;
    rsp_t        r;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready_o) got = 1;
    end
    lat = -1;
    if (!got) begin
      timeout_fail("ready_timeout");
      return;
    end
    off  = addr[1:0];
    idx  = int'(addr[7:2]);
    size = acc_size(f3);
    err  = m_err(we, f3, off);
    if (!err) begin
      b.we    = we;
      b.addr  = addr & ~32'h3;
      for (int k = 0; k < 4; k++) begin
        b.be[k]            = (k >= int'(off)) && (k < int'(off) + size);
        b.wdata[8*k +: 8]  = wdata[8*(k % size) +: 8];
      end
      exp_bus.push_back(b);
      if (we) begin
        for (int i = 0; i < size; i++)
          ref_mem[idx][8*(int'(off)+i) +: 8] = wdata[8*i +: 8];
      end else begin
        mdl_ld = m_load(ref_mem[idx], f3, off);
      end
    end
    r.err = err;
    r.ld  = mdl_ld;
    exp_rsp.push_back(r);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    got = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        lat = i;
        got = 1;
      end
    end
    if (!got) timeout_fail("rsp_timeout");
    tx_id++;
    $display("[TB] tx %0d we=%0d f3=%0d addr=%08h wdata=%08h err=%0d lat=%0d",
             tx_id, we, f3, addr, wdata, err, lat);
  endtask

  task automatic run_chk(input string name, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int lat;
    int exp_lat;
    if (m_err(we, f3, addr[1:0])) exp_lat = 1;
    else if (we)                  exp_lat = 2 + gnt_delay;
    else                          exp_lat = 3 + gnt_delay + rv_delay;
    issue(we, f3, addr, wdata, lat);
    chk(name, lat, exp_lat);
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    int         gcnt;
    bit         in_req;
    bit         pend;
    int         rcnt;
    int         ridx;
    bus_t       b;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    gcnt = 0; in_req = 0; pend = 0; rcnt = 0; ridx = 0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
      if (pend) begin
        if (rcnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = bmem[ridx];
          pend = 0;
        end else begin
          rcnt--;
        end
      end else if (rst_n && bus.mem_req_o) begin
        if (exp_bus.size() == 0) begin
          timeout_fail("spurious_req");
        end else begin
          b = exp_bus[0];
          chk("bus_we",   {31'h0, bus.mem_we_o}, {31'h0, b.we});
          chk("bus_addr", bus.mem_addr_o, b.addr);
          if (b.we) begin
            chk("bus_be",    {28'h0, bus.mem_be_o}, {28'h0, b.be});
            chk("bus_wdata", bus.mem_wdata_o, b.wdata);
          end
          chk("ready_in_req", {31'h0, req_ready_o}, 32'd0);
        end
        if (!in_req) begin
          gcnt   = gnt_delay;
          in_req = 1;
        end
        if (gcnt == 0) begin
          bus.mem_gnt_i = 1'b1;
          in_req = 0;
          if (exp_bus.size() > 0) exp_bus.delete(0);
          if (bus.mem_we_o) begin
            for (int k = 0; k < 4; k++)
              if (bus.mem_be_o[k])
                bmem[bus.mem_addr_o[7:2]][8*k +: 8] = bus.mem_wdata_o[8*k +: 8];
          end else begin
            pend = 1;
            rcnt = rv_delay;
            ridx = int'(bus.mem_addr_o[7:2]);
            if (spur_rv) begin
              bus.mem_rvalid_i = 1'b1;
              bus.mem_rdata_i  = $urandom;
            end
          end
        end else begin
          gcnt--;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid_o) begin
          if (exp_rsp.size() == 0) begin
            timeout_fail("spurious_rsp");
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_err", {31'h0, err_o}, {31'h0, e.err});
            chk("rsp_ld",  ld_data_o, e.ld);
            exp_ld_now = e.ld;
          end
        end else begin
          chk("ld_hold", ld_data_o, exp_ld_now);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [31:0] a;
    bus_t        b;
    bit          w;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      bmem[i]    = ref_mem[i];
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    gnt_delay = 0; rv_delay = 0; spur_rv = 0;
    poke(32'h100, 32'hDEADBEEF);
    run_chk("lat_lw", 1'b0, 3'd2, 32'h100, 32'h0);
    poke(32'h103, 32'h80FF_0000);
    run_chk("lat_lb", 1'b0, 3'd0, 32'h103, 32'h0);
    run_chk("lat_lbu", 1'b0, 3'd4, 32'h103, 32'h0);
    run_chk("lat_sh", 1'b1, 3'd1, 32'h202, 32'h0000_1234);
    run_chk("lat_err", 1'b0, 3'd2, 32'h101, 32'h0);
    gnt_delay = 3;
    run_chk("lat_sw_stall", 1'b1, 3'd2, 32'h104, 32'hCAFE_F00D);
    gnt_delay = 0; spur_rv = 1;
    run_chk("lat_spur_rv", 1'b0, 3'd5, 32'h106, 32'h0);
    spur_rv = 0;
    run_chk("lat_ill_st", 1'b1, 3'd3, 32'h108, 32'h0);

    // Reset while a load waits for rvalid: transaction must vanish.
    gnt_delay = 0; rv_delay = 4;
    @(negedge clk);
    b.we = 1'b0; b.addr = 32'h100; b.wdata = '0; b.be = '0;
    exp_bus.push_back(b);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_ld = '0;
    exp_ld_now = '0;
    @(negedge clk);
    check_reset_vals("rst_abort");
    repeat (10) @(negedge clk);
    $display("[TB] tx reset-abort checked");

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(0, 3);
      spur_rv   = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255);
      run_chk("lat_rand", w, 3'($urandom_range(0, 7)), a, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("rsp_queue_empty", exp_rsp.size(), 32'd0);
    chk("bus_queue_empty", exp_bus.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
